prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, byte-stream valid from the serial receiver.
REQ-004 SHALL have port in_data, input, 8, stream byte.
REQ-005 SHALL have port in_ready, output, 1, loader accepts a byte this cycle.
REQ-006 SHALL have port addr, output, 32 (ADDR_LEN), byte address of the current write.
REQ-007 SHALL have port data, output, 128, load data; newest word in [127:96].
REQ-008 SHALL have port we_32, output, 1, one-cycle dmem word write strobe.
REQ-009 SHALL have port we_128, output, 1, one-cycle imem line write strobe.
REQ-010 SHALL have port done, output, 1, load complete (sticky until reset).
REQ-011 SHALL have port err, output, 1, checksum mismatch (sticky until reset).

Function
REQ-012 SHALL accept a byte only when in_valid && in_ready, in that cycle.
REQ-013 SHALL run FSM states HDR -> DATA -> (CHK) -> DONE; HDR on reset.
REQ-014 In HDR, SHALL take 4 bytes, little-endian, as line count L (32-bit, 16 bytes per line).
REQ-015 SHALL go from HDR directly to DONE (or CHK) when L == 0, issuing no writes.
REQ-016 In DATA, SHALL assemble bytes little-endian into 32-bit words; word k = bytes 4k..4k+3.
REQ-017 On the cycle after the 4th byte of word k is accepted: we_32=1, addr=4*k, data={word_k, previous data[127:32]}.
REQ-018 On every 4th word (k%4==3), SHALL also assert we_128 in the same cycle. data[31:0]=word k-3 and addr[12:4] selects that line.
REQ-019 Word index SHALL be 30 bits wide; addr SHALL wrap modulo 2^32 without error.
REQ-020 SHALL leave DATA after the we_128 of line L-1.
REQ-021 in_ready SHALL be 1 in HDR, DATA and CHK, and 0 in DONE and during any reset cycle.
REQ-022 Gaps in in_valid SHALL stall assembly with no loss or duplication of bytes.
REQ-023 done SHALL rise the cycle after DONE is entered.
REQ-024 After DONE, SHALL ignore further bytes.
REQ-025 we_32/we_128 SHALL never assert outside DATA-generated write cycles.

Reset
REQ-026 Reset SHALL return to HDR and clear byte/word/line counters.
REQ-027 Reset SHALL force outputs: addr=0, data=0, we_32=0, we_128=0, done=0, err=0.
REQ-028 Reset mid-load SHALL abandon the partial word with no write; the next load restarts at addr 0.

Configuration
REQ-029 With PLOADER_CHECKSUM_EN defined: after the last line, state CHK takes 4 more bytes (LE).
REQ-030 CHK SHALL compare those bytes to the mod-2^32 sum of all data words; on mismatch err=1 together with done.
REQ-031 Without PLOADER_CHECKSUM_EN: no CHK state, no trailing bytes, err tied 0.

Structure
REQ-032 Shared package ploader_pkg SHALL hold the FSM state encoding, HDR_BYTES=4, WORDS_PER_LINE=4, and ADDR_LEN/DATA_LEN.
REQ-033 Sub-module ploader_word_asm SHALL do byte-to-word assembly with a word-complete pulse.
REQ-034 Top level SHALL hold the FSM, counters, 128-bit shift register and checksum.

Verification
REQ-035 Header 01 00 00 00, bytes 00..0F: we_32 at addr 0,4,8,C; one we_128 at addr 0xC with data=0x0F0E0D0C_0B0A0908_07060504_03020100; then done=1.
REQ-036 Header 00 00 00 00: no writes; done=1 after 4th header byte (+CHK bytes if enabled).
REQ-037 L=2 with random in_valid gaps: 8 we_32 and 2 we_128 with correct data; no byte lost.
REQ-038 Reset asserted after 6 data bytes, then new L=1 load: first we_32 at addr 0 with new data.
REQ-039 PLOADER_CHECKSUM_EN, L=1 words 1,2,3,4: checksum 0x0000000A -> err=0; 0x0000000B -> err=1; done=1 in both.
REQ-040 Bytes sent after done: in_ready=0 and no strobes.

Source files
------------

// File: rtl/ploader_pkg.sv
// rtl/ploader_pkg.sv - shared types and constants for the program loader
// Purpose: FSM state encoding and sizing constants used by prog_loader and
//          its byte-to-word assembler.
// Ports:   none (package).
package ploader_pkg;

    localparam int HDR_BYTES      = 4;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_LEN       = 32;
    localparam int DATA_LEN       = 128;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_CHK  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/ploader_word_asm.sv
// rtl/ploader_word_asm.sv - little-endian byte to 32-bit word assembler
// Purpose: collects accepted bytes into 32-bit words, first byte in [7:0].
//          word_done_o pulses combinationally in the cycle the 4th byte of a
//          word is presented, with word_o holding the complete word.
// Ports:   clk, reset      - clock, synchronous active-high reset
//          byte_valid_i    - a byte is accepted this cycle
//          byte_i          - the accepted byte
//          word_done_o     - this byte completes a word
//          word_o          - the completed word (valid with word_done_o)
module ploader_word_asm (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_done_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q;
    logic [23:0] sh_q;

    // Bytes enter at the top and move down, so after three bytes sh_q holds
    // {b2, b1, b0} and the fourth byte completes {b3, b2, b1, b0}.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= 2'd0;
            sh_q  <= 24'd0;
        end else if (byte_valid_i) begin
            cnt_q <= cnt_q + 2'd1;
            sh_q  <= {byte_i, sh_q[23:8]};
        end
    end

    assign word_done_o = byte_valid_i && (cnt_q == 2'd3);
    assign word_o      = {byte_i, sh_q};

endmodule

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing dmem words and imem lines
// Purpose: parses a 4-byte little-endian line count L, then 16*L data bytes,
//          issuing a dmem word write per 4 bytes and an imem line write per
//          4 words. Defining PLOADER_CHECKSUM_EN adds a trailing 4-byte
//          checksum (mod-2^32 sum of data words) reported through err.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          in_valid, in_data   - incoming byte stream
//          in_ready            - a byte is accepted when in_valid && in_ready
//          addr                - byte address of the current write
//          data                - last four words, newest in [127:96]
//          we_32, we_128       - one-cycle word / line write strobes
//          done, err           - sticky completion / checksum-mismatch flags
module prog_loader
    import ploader_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic [ADDR_LEN-1:0] addr,
    output logic [DATA_LEN-1:0] data,
    output logic                we_32,
    output logic                we_128,
    output logic                done,
    output logic                err
);

`ifdef PLOADER_CHECKSUM_EN
    localparam state_t ST_AFTER_DATA = ST_CHK;
`else
    localparam state_t ST_AFTER_DATA = ST_DONE;
`endif

    state_t              state_q, state_d;
    logic [1:0]          hdr_cnt_q, hdr_cnt_d;
    logic [23:0]         hdr_sh_q, hdr_sh_d;
    logic [31:0]         len_q, len_d;
    logic [29:0]         word_idx_q, word_idx_d;
    logic [31:0]         line_cnt_q, line_cnt_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic                we32_q, we32_d;
    logic                we128_q, we128_d;
    logic                done_q, done_d;
`ifdef PLOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
    logic                mis_q, mis_d;
    logic                err_q, err_d;
`endif

    logic        accept;
    logic [31:0] hdr_word;
    logic        word_done;
    logic [31:0] word;
    logic        line_end;
    logic        last_line;

    assign in_ready = !reset && (state_q != ST_DONE);
    assign accept   = in_valid && in_ready;
    // Header and checksum share one little-endian byte collector.
    assign hdr_word = {in_data, hdr_sh_q};

    ploader_word_asm u_word_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (accept && (state_q == ST_DATA)),
        .byte_i       (in_data),
        .word_done_o  (word_done),
        .word_o       (word)
    );

    assign line_end  = word_done && (word_idx_q[1:0] == 2'(WORDS_PER_LINE - 1));
    assign last_line = line_end && (line_cnt_q == len_q - 32'd1);

    always_comb begin
        state_d    = state_q;
        hdr_cnt_d  = hdr_cnt_q;
        hdr_sh_d   = hdr_sh_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        line_cnt_d = line_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        we32_d     = 1'b0;
        we128_d    = 1'b0;
        // done trails entry into DONE by one cycle.
        done_d     = done_q | (state_q == ST_DONE);
`ifdef PLOADER_CHECKSUM_EN
        sum_d      = sum_q;
        mis_d      = mis_q;
        err_d      = err_q | ((state_q == ST_DONE) && mis_q);
`endif
        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    hdr_sh_d  = {in_data, hdr_sh_q[23:8]};
                    if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                        len_d   = hdr_word;
                        state_d = (hdr_word == 32'd0) ? ST_AFTER_DATA : ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_done) begin
                    we32_d     = 1'b1;
                    addr_d     = {word_idx_q, 2'b00};
                    data_d     = {word, data_q[DATA_LEN-1:32]};
                    word_idx_d = word_idx_q + 30'd1;
`ifdef PLOADER_CHECKSUM_EN
                    sum_d      = sum_q + word;
`endif
                    if (line_end) begin
                        we128_d    = 1'b1;
                        line_cnt_d = line_cnt_q + 32'd1;
                    end
                    if (last_line) begin
                        state_d = ST_AFTER_DATA;
                    end
                end
            end
`ifdef PLOADER_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    hdr_cnt_d = hdr_cnt_q + 2'd1;
                    hdr_sh_d  = {in_data, hdr_sh_q[23:8]};
                    if (hdr_cnt_q == 2'(HDR_BYTES - 1)) begin
                        mis_d   = (hdr_word != sum_q);
                        state_d = ST_DONE;
                    end
                end
            end
`endif
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_HDR;
            hdr_cnt_q  <= 2'd0;
            hdr_sh_q   <= 24'd0;
            len_q      <= 32'd0;
            word_idx_q <= 30'd0;
            line_cnt_q <= 32'd0;
            addr_q     <= '0;
            data_q     <= '0;
            we32_q     <= 1'b0;
            we128_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef PLOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
            mis_q      <= 1'b0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            hdr_cnt_q  <= hdr_cnt_d;
            hdr_sh_q   <= hdr_sh_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            line_cnt_q <= line_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            we32_q     <= we32_d;
            we128_q    <= we128_d;
            done_q     <= done_d;
`ifdef PLOADER_CHECKSUM_EN
            sum_q      <= sum_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
`endif
        end
    end

    assign addr   = addr_q;
    assign data   = data_q;
    assign we_32  = we32_q;
    assign we_128 = we128_q;
    assign done   = done_q;
`ifdef PLOADER_CHECKSUM_EN
    assign err    = err_q;
`else
    assign err    = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader
module tb_prog_loader;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         we_32;
    logic         we_128;
    logic         done;
    logic         err;

    always #5 clk = ~clk;

    prog_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .addr     (addr),
        .data     (data),
        .we_32    (we_32),
        .we_128   (we_128),
        .done     (done),
        .err      (err)
    );

    int total  = 0;
    int passed = 0;

    logic [31:0]  cap32_addr[$];
    logic [127:0] cap32_data[$];
    logic [31:0]  cap128_addr[$];
    logic [127:0] cap128_data[$];
    logic [7:0]   src[$];

    always @(negedge clk) begin
        if (we_32) begin
            cap32_addr.push_back(addr);
            cap32_data.push_back(data);
        end
        if (we_128) begin
            cap128_addr.push_back(addr);
            cap128_data.push_back(data);
        end
    end

    task automatic clear_caps();
        cap32_addr.delete();
        cap32_data.delete();
        cap128_addr.delete();
        cap128_data.delete();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        int t;
        n = (gap > 0) ? int'($urandom_range(0, gap)) : 0;
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        #1;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        total++;
        if (t >= 50) begin
            $display("FAIL send_byte_timeout: in_ready=%0b never 1 within 50 cycles", in_ready);
            in_valid = 1'b0;
            return;
        end
        passed++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic gen_random(input int lines);
        src.delete();
        for (int i = 0; i < 16 * lines; i++) src.push_back(8'($urandom));
    endtask

    // Sends header + src bytes (+ checksum offset by csum_delta) and checks
    // every write against a model built from the word list.
    task automatic run_load(input int lines, input int gap, input logic [31:0] csum_delta);
        logic [31:0]  lw;
        logic [31:0]  words[$];
        logic [31:0]  sum;
        logic [127:0] e;
        logic         exp_err;
        lw  = 32'(lines);
        sum = 32'd0;
        clear_caps();
        for (int i = 0; i < 4; i++) send_byte(lw[8*i +: 8], gap);
        for (int i = 0; i < src.size(); i++) send_byte(src[i], gap);
        for (int k = 0; k < src.size() / 4; k++) begin
            words.push_back({src[4*k+3], src[4*k+2], src[4*k+1], src[4*k]});
            sum = sum + words[k];
        end
`ifdef PLOADER_CHECKSUM_EN
        sum = sum + csum_delta;
        for (int i = 0; i < 4; i++) send_byte(sum[8*i +: 8], gap);
        exp_err = (csum_delta != 32'd0);
`else
        exp_err = 1'b0;
`endif
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cap32_addr.size() !== 4 * lines)
            $display("FAIL we32_count: got %0d want %0d", cap32_addr.size(), 4 * lines);
        else passed++;
        total++;
        if (cap128_addr.size() !== lines)
            $display("FAIL we128_count: got %0d want %0d", cap128_addr.size(), lines);
        else passed++;
        for (int k = 0; k < words.size() && k < cap32_addr.size(); k++) begin
            e = '0;
            for (int j = 0; j < 4; j++)
                if (k - j >= 0) e[127 - 32*j -: 32] = words[k - j];
            total++;
            if (cap32_addr[k] !== 32'(4 * k))
                $display("FAIL we32_addr[%0d]: got %h want %h", k, cap32_addr[k], 32'(4 * k));
            else passed++;
            total++;
            if (cap32_data[k] !== e)
                $display("FAIL we32_data[%0d]: got %h want %h", k, cap32_data[k], e);
            else passed++;
            if ((k % 4) == 3 && (k / 4) < cap128_addr.size()) begin
                total++;
                if (cap128_addr[k/4] !== 32'(4 * k) || cap128_data[k/4] !== e)
                    $display("FAIL we128[%0d]: got %h/%h want %h/%h", k / 4,
                             cap128_addr[k/4], cap128_data[k/4], 32'(4 * k), e);
                else passed++;
            end
        end
        total++;
        if (done !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL load_done: got done=%b in_ready=%b want 1/0", done, in_ready);
        else passed++;
        total++;
        if (err !== exp_err)
            $display("FAIL load_err: got %b want %b", err, exp_err);
        else passed++;
    endtask

    task automatic test_reset();
        in_valid = 1'b0;
        in_data  = 8'h00;
        reset    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (addr !== 32'd0 || data !== 128'd0 || we_32 !== 1'b0 || we_128 !== 1'b0 ||
            done !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL reset_state: addr=%h data=%h we32=%b we128=%b done=%b err=%b rdy=%b",
                     addr, data, we_32, we_128, done, err, in_ready);
        else passed++;
        reset = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL ready_after_reset: got %b want 1", in_ready);
        else passed++;
    endtask

    task automatic test_single_line();
        do_reset();
        src.delete();
        for (int i = 0; i < 16; i++) src.push_back(8'(i));
        run_load(1, 0, 32'd0);
        total++;
        if (cap128_data.size() < 1 ||
            cap128_data[0] !== 128'h0F0E0D0C_0B0A0908_07060504_03020100)
            $display("FAIL single_line_data: got %h want 0f0e0d0c0b0a090807060504_03020100",
                     (cap128_data.size() > 0) ? cap128_data[0] : 128'hx);
        else passed++;
    endtask

    task automatic test_zero_len();
        do_reset();
        clear_caps();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
`ifdef PLOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
`endif
        total++;
        if (done !== 1'b0)
            $display("FAIL zero_len_done_early: got %b want 0", done);
        else passed++;
        @(negedge clk);
        total++;
        if (done !== 1'b1)
            $display("FAIL zero_len_done: got %b want 1", done);
        else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (cap32_addr.size() !== 0 || cap128_addr.size() !== 0 || err !== 1'b0)
            $display("FAIL zero_len_writes: got %0d/%0d err=%b want 0/0 err=0",
                     cap32_addr.size(), cap128_addr.size(), err);
        else passed++;
    endtask

    task automatic test_random_gaps();
        do_reset();
        gen_random(2);
        run_load(2, 3, 32'd0);
        do_reset();
        gen_random(3);
        run_load(3, 0, 32'd0);
    endtask

    task automatic test_reset_midload();
        do_reset();
        clear_caps();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h01 : 8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
        @(negedge clk);
        total++;
        if (cap32_addr.size() !== 1)
            $display("FAIL midload_writes: got %0d want 1", cap32_addr.size());
        else passed++;
        do_reset();
        @(negedge clk);
        total++;
        if (cap32_addr.size() !== 1 || cap128_addr.size() !== 0)
            $display("FAIL midload_after_reset: got %0d/%0d want 1/0",
                     cap32_addr.size(), cap128_addr.size());
        else passed++;
        gen_random(1);
        run_load(1, 2, 32'd0);
    endtask

    task automatic test_after_done();
        clear_caps();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            #1;
            total++;
            if (in_ready !== 1'b0)
                $display("FAIL after_done_ready[%0d]: got %b want 0", i, in_ready);
            else passed++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (cap32_addr.size() !== 0 || cap128_addr.size() !== 0 || done !== 1'b1)
            $display("FAIL after_done_strobes: got %0d/%0d done=%b want 0/0 done=1",
                     cap32_addr.size(), cap128_addr.size(), done);
        else passed++;
    endtask

    task automatic test_checksum();
        src.delete();
        for (int w = 1; w <= 4; w++) begin
            src.push_back(8'(w));
            src.push_back(8'h00);
            src.push_back(8'h00);
            src.push_back(8'h00);
        end
        do_reset();
        run_load(1, 0, 32'd0);
        do_reset();
        run_load(1, 1, 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        test_reset();
        test_single_line();
        test_after_done();
        test_zero_len();
        test_random_gaps();
        test_reset_midload();
        test_checksum();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
